// File: rtl/usb_slave_trans_ctrl.sv
// Purpose : USB device-side transaction engine; answers host tokens with DATA0/1, ACK, NAK or STALL.
// Latency : token accepted -> endpoint checked next cycle; response PID requested once the send path is idle.
// Backpr. : holds the response in SEND_PKT while sendPacketRdy=0; no input is ever stalled (pulses only).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   devAddr, slaveEn              device address and global enable from the register bus
//   rxToken*/rxData*/rxHs*        decoded token, data-packet-end and handshake pulses from the receive path
//   endPSel, ep*                  latched endpoint index out, that endpoint's controls back (one cycle later)
//   sendPacket*                   one-cycle transmit request + PID, and the send path's idle flag
//   SOFRx                         pulse on every SOF token while enabled
//   transDone, transStatus        completion pulse and status {type[1:0], iso, seqErr, timeout, stall, nak, ack}
//   epSeqToggle                   pulse asking the registers to flip the endpoint data sequence bit
module usb_slave_trans_ctrl #(
  parameter logic [7:0] RX_TIMEOUT = 8'd92,
  parameter int         NUM_ENDP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] devAddr,
  input  logic       slaveEn,
  input  logic       rxTokenValid,
  input  logic [3:0] rxTokenPID,
  input  logic [6:0] rxTokenAddr,
  input  logic [3:0] rxTokenEndP,
  input  logic       rxDataDone,
  input  logic [3:0] rxDataPID,
  input  logic       rxDataError,
  input  logic       rxHsValid,
  input  logic [3:0] rxHsPID,
  output logic [3:0] endPSel,
  input  logic       epReady,
  input  logic       epStall,
  input  logic       epIsoEn,
  input  logic       epDataSeq,
  output logic       sendPacketWEn,
  output logic [3:0] sendPacketPID,
  input  logic       sendPacketRdy,
  output logic       SOFRx,
  output logic       transDone,
  output logic [7:0] transStatus,
  output logic       epSeqToggle
);

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [4:0] NUM_ENDP_L = 5'(NUM_ENDP);
  localparam logic [7:0] CNT_LAST   = RX_TIMEOUT - 8'd1;

  typedef enum logic [2:0] {
    IDLE, CHK_EP, WAIT_DATA, SEND_PKT, WAIT_SEND, WAIT_ACK, DONE
  } state_t;

  state_t     state, stateNext;
  logic [3:0] tokPID, tokPIDNext;
  logic [3:0] endPSelNext;
  logic [7:0] cnt, cntNext;
  logic [3:0] respPID, respPIDNext;
  logic       sawLow, sawLowNext;
  logic       stAck, stAckNext;
  logic       stNak, stNakNext;
  logic       stStall, stStallNext;
  logic       stTimeout, stTimeoutNext;
  logic       stSeqErr, stSeqErrNext;
  logic       stIso, stIsoNext;
  logic       doToggle, doToggleNext;
  logic       sendWEnNext;
  logic [3:0] sendPIDNext;
  logic       sofNext;
  logic [1:0] typeBits;

  logic tokXfer, tokMatch, dataPIDOk, dataParity, outSeqErr;

  assign tokXfer    = (rxTokenPID == PID_IN) || (rxTokenPID == PID_OUT) || (rxTokenPID == PID_SETUP);
  assign tokMatch   = (rxTokenAddr == devAddr) && ({1'b0, rxTokenEndP} < NUM_ENDP_L);
  assign dataPIDOk  = (rxDataPID == PID_DATA0) || (rxDataPID == PID_DATA1);
  assign dataParity = (rxDataPID == PID_DATA1);
  // A parity mismatch means the host resent a packet we already took: ACK it, keep the sequence bit.
  assign outSeqErr  = (dataParity != epDataSeq);
  assign typeBits   = (tokPID == PID_IN)  ? 2'b01 :
                      (tokPID == PID_OUT) ? 2'b10 : 2'b00;

  assign transDone   = (state == DONE);
  assign epSeqToggle = (state == DONE) && doToggle;

  always_comb begin
    stateNext     = state;
    tokPIDNext    = tokPID;
    endPSelNext   = endPSel;
    cntNext       = cnt;
    respPIDNext   = respPID;
    sawLowNext    = sawLow;
    stAckNext     = stAck;
    stNakNext     = stNak;
    stStallNext   = stStall;
    stTimeoutNext = stTimeout;
    stSeqErrNext  = stSeqErr;
    stIsoNext     = stIso;
    doToggleNext  = doToggle;
    sendWEnNext   = 1'b0;
    sendPIDNext   = sendPacketPID;
    sofNext       = 1'b0;
    case (state)
      IDLE: begin
        if (rxTokenValid && slaveEn) begin
          if (rxTokenPID == PID_SOF) begin
            sofNext = 1'b1;
          end else if (tokXfer && tokMatch) begin
            tokPIDNext    = rxTokenPID;
            endPSelNext   = rxTokenEndP;
            stAckNext     = 1'b0;
            stNakNext     = 1'b0;
            stStallNext   = 1'b0;
            stTimeoutNext = 1'b0;
            stSeqErrNext  = 1'b0;
            stIsoNext     = 1'b0;
            doToggleNext  = 1'b0;
            stateNext     = CHK_EP;
          end
        end
      end
      CHK_EP: begin
        if (tokPID != PID_IN) begin
          cntNext   = 8'd0;
          stateNext = WAIT_DATA;
        end else begin
          stIsoNext = epIsoEn;
          if (epStall) begin
            respPIDNext = PID_STALL;
            stStallNext = 1'b1;
            stateNext   = SEND_PKT;
          end else if (!epReady) begin
            // Isochronous endpoints never handshake, so an empty one just stays silent.
            if (epIsoEn) begin
              stateNext = IDLE;
            end else begin
              respPIDNext = PID_NAK;
              stNakNext   = 1'b1;
              stateNext   = SEND_PKT;
            end
          end else begin
            respPIDNext = (!epIsoEn && epDataSeq) ? PID_DATA1 : PID_DATA0;
            stateNext   = SEND_PKT;
          end
        end
      end
      WAIT_DATA: begin
        cntNext = cnt + 8'd1;
        if (rxDataDone) begin
          if (rxDataError || !dataPIDOk) begin
            stateNext = IDLE;
          end else if (tokPID == PID_SETUP) begin
            respPIDNext  = PID_ACK;
            stAckNext    = 1'b1;
            stSeqErrNext = (rxDataPID != PID_DATA0);
            doToggleNext = 1'b1;
            stateNext    = SEND_PKT;
          end else begin
            stIsoNext = epIsoEn;
            if (epStall) begin
              respPIDNext = PID_STALL;
              stStallNext = 1'b1;
              stateNext   = SEND_PKT;
            end else if (!epReady) begin
              respPIDNext = PID_NAK;
              stNakNext   = 1'b1;
              stateNext   = SEND_PKT;
            end else if (epIsoEn) begin
              stateNext = DONE;
            end else begin
              respPIDNext  = PID_ACK;
              stAckNext    = 1'b1;
              stSeqErrNext = outSeqErr;
              doToggleNext = !outSeqErr;
              stateNext    = SEND_PKT;
            end
          end
        end else if (cnt == CNT_LAST) begin
          stTimeoutNext = 1'b1;
          stateNext     = DONE;
        end
      end
      SEND_PKT: begin
        if (sendPacketRdy) begin
          sendWEnNext = 1'b1;
          sendPIDNext = respPID;
          sawLowNext  = 1'b0;
          stateNext   = WAIT_SEND;
        end
      end
      WAIT_SEND: begin
        // The packet is only on the wire once the send path has gone busy and come back.
        if (!sendPacketRdy) begin
          sawLowNext = 1'b1;
        end else if (sawLow) begin
          if ((tokPID == PID_IN) && !stIso &&
              ((respPID == PID_DATA0) || (respPID == PID_DATA1))) begin
            cntNext   = 8'd0;
            stateNext = WAIT_ACK;
          end else begin
            stateNext = DONE;
          end
        end
      end
      WAIT_ACK: begin
        cntNext = cnt + 8'd1;
        if (rxHsValid && (rxHsPID == PID_ACK)) begin
          stAckNext    = 1'b1;
          doToggleNext = 1'b1;
          stateNext    = DONE;
        end else if (rxHsValid || rxTokenValid || (cnt == CNT_LAST)) begin
          // Lost or wrong handshake: host will retry, so the sequence bit stays put.
          stTimeoutNext = 1'b1;
          stateNext     = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tokPID        <= 4'h0;
      endPSel       <= 4'h0;
      cnt           <= 8'd0;
      respPID       <= 4'h0;
      sawLow        <= 1'b0;
      stAck         <= 1'b0;
      stNak         <= 1'b0;
      stStall       <= 1'b0;
      stTimeout     <= 1'b0;
      stSeqErr      <= 1'b0;
      stIso         <= 1'b0;
      doToggle      <= 1'b0;
      sendPacketWEn <= 1'b0;
      sendPacketPID <= 4'h0;
      SOFRx         <= 1'b0;
      transStatus   <= 8'h00;
    end else begin
      state         <= stateNext;
      tokPID        <= tokPIDNext;
      endPSel       <= endPSelNext;
      cnt           <= cntNext;
      respPID       <= respPIDNext;
      sawLow        <= sawLowNext;
      stAck         <= stAckNext;
      stNak         <= stNakNext;
      stStall       <= stStallNext;
      stTimeout     <= stTimeoutNext;
      stSeqErr      <= stSeqErrNext;
      stIso         <= stIsoNext;
      doToggle      <= doToggleNext;
      sendPacketWEn <= sendWEnNext;
      sendPacketPID <= sendPIDNext;
      SOFRx         <= sofNext;
      // DONE lasts one cycle and always returns to IDLE, so this loads once per transaction.
      if ((stateNext == DONE) && (state != DONE)) begin
        transStatus <= {typeBits, stIsoNext, stSeqErrNext, stTimeoutNext,
                        stStallNext, stNakNext, stAckNext};
      end
    end
  end

endmodule

// File: doc/usb_slave_trans_ctrl.md
Name: usb_slave_trans_ctrl

Overview:
- Device-side (slave) transaction engine: the responder end of the token/data/handshake exchange that the host controller initiates.
- Consumes decoded tokens, data-packet completions and handshakes from the slave receive path.
- Decides and issues the response PID (DATA0/DATA1/ACK/NAK/STALL, or no response) to the slave send-packet block.
- Reports per-transaction completion to the slave register bus interface.

Parameters:
- RX_TIMEOUT, 8'd92: clk cycles to wait for the host's DATA packet or ACK before abandoning the transaction.
- NUM_ENDP, 4: number of implemented endpoints; tokens with endP >= NUM_ENDP are ignored.

Ports:
- clk  in  1  USB clock (48 MHz); one clock domain.
- rst  in  1  synchronous reset, active-high.
- devAddr  in  7  device address programmed by the register bus.
- slaveEn  in  1  0 = ignore all traffic.
- rxTokenValid  in  1  one-cycle pulse: token packet received with good CRC5.
- rxTokenPID  in  4  token PID (OUT=4'h1, IN=4'h9, SETUP=4'hD, SOF=4'h5).
- rxTokenAddr  in  7  token address field.
- rxTokenEndP  in  4  token endpoint field.
- rxDataDone  in  1  one-cycle pulse: data packet ended.
- rxDataPID  in  4  data PID (DATA0=4'h3, DATA1=4'hB).
- rxDataError  in  1  CRC16 or bit-stuff error on the packet; valid with rxDataDone.
- rxHsValid  in  1  one-cycle pulse: handshake packet received.
- rxHsPID  in  4  handshake PID (ACK=4'h2).
- endPSel  out  4  latched endpoint index into the endpoint control registers.
- epReady  in  1  control for endPSel; valid the cycle after endPSel changes.
- epStall  in  1  control for endPSel; same timing as epReady.
- epIsoEn  in  1  control for endPSel; same timing as epReady.
- epDataSeq  in  1  control for endPSel; same timing as epReady.
- sendPacketWEn  out  1  one-cycle request to transmit sendPacketPID.
- sendPacketPID  out  4  PID to transmit.
- sendPacketRdy  in  1  send path idle; falls while a packet is in transit.
- SOFRx  out  1  one-cycle pulse on an SOF token (slaveEn=1, address not checked).
- transDone  out  1  one-cycle pulse at transaction completion.
- transStatus  out  8  status captured at transDone; holds until the next transDone.
- epSeqToggle  out  1  one-cycle pulse: toggle the data sequence bit of endPSel.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Resetting mid-transaction aborts it with no transDone.
- States: IDLE, CHK_EP, WAIT_DATA, SEND_PKT, WAIT_SEND, WAIT_ACK, DONE.
- IDLE: a token is accepted when rxTokenValid=1, slaveEn=1, rxTokenAddr==devAddr, rxTokenEndP<NUM_ENDP and PID is IN/OUT/SETUP.
  - On accept: latch PID and endP (endPSel updates next edge), go to CHK_EP.
  - Any other token is ignored. SOF pulses SOFRx and stays in IDLE.
- CHK_EP (1 cycle, endpoint controls sampled here):
  - SETUP or OUT: go to WAIT_DATA, timeout counter cleared.
  - IN, epStall=1: PID=STALL (4'hE).
  - IN, epReady=0, non-iso: PID=NAK (4'hA).
  - IN, epReady=0, iso: go to IDLE, no transDone.
  - IN, epReady=1: PID = DATA0 if iso, else epDataSeq ? DATA1 : DATA0.
  - Whenever a PID is selected, go to SEND_PKT.
- WAIT_DATA: counter increments each cycle. Counter == RX_TIMEOUT-1 without rxDataDone: DONE with timeout bit set.
- On rxDataDone in WAIT_DATA:
  - rxDataError=1 or PID not DATA0/1: go to IDLE silently (no handshake, no transDone).
  - SETUP: always ACK; stall is ignored; seqErr if rxDataPID!=DATA0.
  - OUT, epStall=1: STALL.
  - OUT, epReady=0: NAK.
  - OUT, iso: no handshake, DONE.
  - OUT, otherwise: ACK. Data PID parity != epDataSeq sets seqErr (duplicate packet): still ACK, but no epSeqToggle.
- SEND_PKT: wait for sendPacketRdy=1, then assert sendPacketWEn for exactly one cycle with the PID, go to WAIT_SEND.
- WAIT_SEND: wait for sendPacketRdy to fall and then rise again.
  - After IN data, non-iso: go to WAIT_ACK, counter cleared.
  - Otherwise: DONE.
- WAIT_ACK:
  - rxHsValid with ACK: success, DONE.
  - Timeout, another PID, or a new rxTokenValid: DONE with timeout bit set, no toggle.
  - A new token arriving here is not accepted; the host retries it.
- DONE (1 cycle): transDone=1 and transStatus updated.
  - epSeqToggle pulses the same cycle on successful non-iso ACKed OUT without seqErr, on SETUP, and on an IN whose data was ACKed.
  - Next state is IDLE.
- transStatus bits:
  - [0] ACK sent or received
  - [1] NAK sent
  - [2] STALL sent
  - [3] timeout
  - [4] seqErr
  - [5] iso
  - [7:6] type (00 SETUP, 01 IN, 10 OUT)
- slaveEn falling mid-transaction: the current transaction completes normally; new tokens are ignored.

Test Plan:
- devAddr=7'h05, SETUP token addr 5 ep0, then DATA0 good → SEND_PKT issues ACK(4'h2); transDone; transStatus=8'h01; epSeqToggle=1.
- OUT ep1 with epStall=1 → STALL sent; transStatus=8'h84; epSeqToggle=0. Repeat with epReady=0 → NAK, status 8'h82.
- IN ep2, epReady=1, epDataSeq=1 → DATA1(4'hB) issued only once sendPacketRdy=1; host ACK 20 cycles later → transStatus=8'h41, epSeqToggle=1.
- IN with no ACK → transDone exactly RX_TIMEOUT cycles after WAIT_ACK entry, status 8'h48, no toggle.
- OUT with epDataSeq=0 receiving DATA1 → ACK sent, status 8'h91, no toggle. Separately, rxDataError=1 → no sendPacketWEn and no transDone.
- Token addr 6 (mismatch) and ep 4 → ignored. SOF → SOFRx pulse only. Assert rst while in WAIT_SEND → all outputs 0 next cycle, no transDone.
